// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: issues in-order word reads and buffers the returned
// instructions, with their PCs, in a DEPTH-entry queue for the decode stage.
module fetch_prefetch #(
  parameter int unsigned          DEPTH    = 4,
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      mem_req_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [31:0]               mem_rdata_i,
  input  logic                      redirect_i,
  input  logic [ADDR_W-1:0]         redirect_pc_i,
  output logic                      instr_valid_o,
  output logic [31:0]               instr_o,
  output logic [ADDR_W-1:0]         instr_pc_o,
  input  logic                      instr_ready_i,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned       PTR_W   = $clog2(DEPTH);
  localparam int unsigned       CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] WORD    = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic              block_q, block_d;

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic              grant, rsp, push, pop;
  logic [CNT_W:0]    in_flight;
  logic [ADDR_W-1:0] target_pc;

  // Queue occupancy plus every granted-but-unanswered request (discards
  // included) must stay below DEPTH, so each grant owns a free slot.
  assign in_flight = {1'b0, count_q} + {1'b0, outst_q};
  assign mem_req_o = !reset && !block_q && (in_flight < DEPTH_C);
  assign mem_addr_o = fetch_pc_q;

  assign grant     = mem_req_o && mem_gnt_i;
  assign rsp       = mem_rvalid_i && (outst_q != '0);
  assign pop       = (count_q != '0) && instr_ready_i;
  assign push      = rsp && (discard_q == '0) && !redirect_i;
  assign target_pc = {redirect_pc_i[ADDR_W-1:2], 2'b00};

  assign instr_valid_o = !reset && (count_q != '0);
  assign count_o       = reset ? '0 : count_q;
  assign instr_o       = instr_mem[head_q];
  assign instr_pc_o    = pc_mem[head_q];

  // NOTE: every _d gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    fetch_pc_d = grant ? fetch_pc_q + WORD : fetch_pc_q;
    rsp_pc_d   = push ? rsp_pc_q + WORD : rsp_pc_q;
    head_d     = pop ? head_q + 1'b1 : head_q;
    tail_d     = push ? tail_q + 1'b1 : tail_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    outst_d    = outst_q + CNT_W'(grant) - CNT_W'(rsp);
    discard_d  = (rsp && discard_q != '0) ? discard_q - 1'b1 : discard_q;
    block_d    = redirect_i;

    // Redirect wins over everything this cycle: the flush discards any
    // response arriving now and every request still in flight.
    if (redirect_i) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      discard_d  = outst_d;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      block_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      block_q    <= block_d;
    end
  end

  // NOTE: queue storage has no reset; an entry is only read once count says
  // it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= mem_rdata_i;
      pc_mem[tail_q]    <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: streaming, backpressure, redirects,
// address wrap, spurious responses and mid-stream reset.
module tb_fetch_prefetch;

  logic        clk;
  logic        reset;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        ready;
  logic [2:0]  count_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [2:0]  w_count;

  logic        rsp_on;
  logic        spur;
  int          n_checks;
  int          n_fail;
  int          n_grants;
  logic [31:0] pend_q [$];

  fetch_prefetch #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (ready),
    .count_o       (count_o)
  );

  // Always-granted fetcher near the top of memory, used for the wrap check.
  fetch_prefetch #(.DEPTH(4), .ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) wrap_dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_o     (w_req),
    .mem_addr_o    (w_addr),
    .mem_gnt_i     (1'b1),
    .mem_rvalid_i  (1'b0),
    .mem_rdata_i   (32'h0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .instr_valid_o (w_valid),
    .instr_o       (w_instr),
    .instr_pc_o    (w_pc),
    .instr_ready_i (1'b0),
    .count_o       (w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return addr ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: memory model answers the oldest grant (latency 1 or more),
  // then records this cycle's grant, then the edge is taken.
  task automatic cycle();
    if (rsp_on && !reset && pend_q.size() != 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = data_of(pend_q.pop_front());
    end else if (spur) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    #1;
    if (!reset && mem_req_o && mem_gnt) begin
      pend_q.push_back(mem_addr_o);
      n_grants++;
    end
    @(posedge clk);
    #1;
    if (reset) pend_q.delete();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ready    = 1'b0;
    redirect = 1'b0;
    rsp_on   = 1'b0;
    spur     = 1'b0;
    cycle();
    check("rst_req", mem_req_o, 32'd0);
    check("rst_valid", instr_valid_o, 32'd0);
    check("rst_count", count_o, 32'd0);
    check("rst_addr", mem_addr_o, 32'h100);
    cycle();
    reset = 1'b0;
    #1;
    check("rel_req", mem_req_o, 32'd1);
    check("rel_addr", mem_addr_o, 32'h100);
  endtask

  initial begin
    reset = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
    rsp_on = 1'b0; spur = 1'b0;
    n_checks = 0; n_fail = 0; n_grants = 0;
    @(posedge clk);
    #1;

    // Streaming from RESET_PC, plus the wrap instance released alongside.
    do_reset();
    check("wrap_addr0", w_addr, 32'hFFFF_FFF8);
    mem_gnt = 1'b1; rsp_on = 1'b1; ready = 1'b1;
    cycle();
    check("stream_latency_valid", instr_valid_o, 32'd0);
    check("stream_addr1", mem_addr_o, 32'h104);
    check("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_addr2", w_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) begin
      check("stream_valid", instr_valid_o, 32'd1);
      check("stream_pc", instr_pc_o, 32'h100 + 32'(4 * i));
      check("stream_data", instr_o, data_of(32'h100 + 32'(4 * i)));
      check("stream_req", mem_req_o, 32'd1);
      cycle();
    end

    // Backpressure: exactly DEPTH grants, then requests stop until pops.
    mem_gnt = 1'b1;
    do_reset();
    rsp_on = 1'b1; ready = 1'b0; n_grants = 0;
    repeat (10) cycle();
    check("bp_grants", n_grants, 32'd4);
    check("bp_count", count_o, 32'd4);
    check("bp_req", mem_req_o, 32'd0);
    check("bp_head_pc", instr_pc_o, 32'h100);
    ready = 1'b1;
    cycle();
    check("bp_pop_count", count_o, 32'd3);
    check("bp_pop_pc", instr_pc_o, 32'h104);
    check("bp_resume_req", mem_req_o, 32'd1);
    check("bp_resume_addr", mem_addr_o, 32'h110);

    // Refill, then reset with a full queue.
    ready = 1'b0;
    cycle();
    cycle();
    check("full_count", count_o, 32'd4);
    do_reset();
    rsp_on = 1'b1; ready = 1'b1;
    cycle();
    cycle();
    check("restart_valid", instr_valid_o, 32'd1);
    check("restart_pc", instr_pc_o, 32'h100);

    // Response with nothing outstanding is ignored and does not skew accounting.
    do_reset();
    mem_gnt = 1'b0; spur = 1'b1;
    cycle();
    spur = 1'b0;
    check("spur_count", count_o, 32'd0);
    check("spur_valid", instr_valid_o, 32'd0);
    check("spur_req", mem_req_o, 32'd1);
    mem_gnt = 1'b1; rsp_on = 1'b1;
    cycle();
    cycle();
    check("spur_after_count", count_o, 32'd1);
    check("spur_after_pc", instr_pc_o, 32'h100);

    // Redirect with three requests outstanding, misaligned target.
    do_reset();
    mem_gnt = 1'b1; rsp_on = 1'b0; ready = 1'b0;
    repeat (3) cycle();
    check("rd_req_pre", mem_req_o, 32'd1);
    check("rd_addr_pre", mem_addr_o, 32'h10C);
    mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h2003;
    cycle();
    redirect = 1'b0; mem_gnt = 1'b1;
    check("rd_req_r1", mem_req_o, 32'd0);
    check("rd_count_r1", count_o, 32'd0);
    cycle();
    check("rd_req_r2", mem_req_o, 32'd1);
    check("rd_addr_r2", mem_addr_o, 32'h2000);
    rsp_on = 1'b1;
    repeat (3) cycle();
    check("rd_dropped_count", count_o, 32'd0);
    cycle();
    check("rd_first_valid", instr_valid_o, 32'd1);
    check("rd_first_pc", instr_pc_o, 32'h2000);
    check("rd_first_data", instr_o, data_of(32'h2000));

    // Redirect in the same cycle as a response, a grant and a pop.
    do_reset();
    mem_gnt = 1'b1; rsp_on = 1'b1; ready = 1'b1;
    repeat (4) cycle();
    check("sc_pre_valid", instr_valid_o, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h3000;
    cycle();
    redirect = 1'b0;
    check("sc_count_r1", count_o, 32'd0);
    check("sc_valid_r1", instr_valid_o, 32'd0);
    check("sc_req_r1", mem_req_o, 32'd0);
    cycle();
    check("sc_valid_r2", instr_valid_o, 32'd0);
    check("sc_req_r2", mem_req_o, 32'd1);
    check("sc_addr_r2", mem_addr_o, 32'h3000);
    cycle();
    check("sc_valid_r3", instr_valid_o, 32'd0);
    cycle();
    check("sc_valid_r4", instr_valid_o, 32'd1);
    check("sc_pc_r4", instr_pc_o, 32'h3000);

    // Back-to-back redirects: the last target wins.
    do_reset();
    mem_gnt = 1'b1; rsp_on = 1'b1; ready = 1'b1;
    repeat (4) cycle();
    redirect = 1'b1; redirect_pc = 32'h4000;
    cycle();
    redirect_pc = 32'h5004;
    cycle();
    redirect = 1'b0;
    check("dr_req_r1", mem_req_o, 32'd0);
    check("dr_count_r1", count_o, 32'd0);
    cycle();
    check("dr_req_r2", mem_req_o, 32'd1);
    check("dr_addr_r2", mem_addr_o, 32'h5004);
    cycle();
    check("dr_valid_r3", instr_valid_o, 32'd0);
    cycle();
    check("dr_valid_r4", instr_valid_o, 32'd1);
    check("dr_pc_r4", instr_pc_o, 32'h5004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
